// File: rtl/avalon_master_rw32_tester.sv
// Avalon-MM 32-bit write/read-back tester: writes a seeded pattern block, reads it back, compares.
// Optional per-access abort when MASTER_TIMEOUT_EN is defined (TIMEOUT_CYC cycles of stall).
module avalon_master_rw32_tester #(
   parameter int ADDR_W      = 6,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              rsi_MRST_reset_n,
   input  logic              csi_MCLK_clk,
   input  logic              ctl_start,
   input  logic [ADDR_W-1:0] ctl_base,
   input  logic [ADDR_W-1:0] ctl_count,
   input  logic [31:0]       ctl_seed,
   output logic              ctl_busy,
   output logic              ctl_done,
   output logic              ctl_pass,
   output logic [ADDR_W:0]   ctl_err_count,
   output logic [ADDR_W-1:0] ctl_first_err_addr,
   output logic              ctl_timeout,
   output logic [ADDR_W-1:0] avm_m0_address,
   output logic [3:0]        avm_m0_byteenable,
   output logic [31:0]       avm_m0_writedata,
   output logic              avm_m0_write,
   output logic              avm_m0_read,
   input  logic [31:0]       avm_m0_readdata,
   input  logic              avm_m0_readdatavalid,
   input  logic              avm_m0_waitrequest
);

   typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, DONE} state_t;

   localparam logic [ADDR_W-1:0] ONE   = 1;
   localparam logic [ADDR_W:0]   ONE_E = 1;

   state_t            state_q, state_n;
   logic [ADDR_W-1:0] base_q, base_n;
   logic [ADDR_W-1:0] cnt_q, cnt_n;
   logic [ADDR_W-1:0] idx_q, idx_n;
   logic [ADDR_W-1:0] fea_q, fea_n;
   logic [31:0]       seed_q, seed_n;
   logic [ADDR_W:0]   err_q, err_n;
   logic              to_q, to_n;
   logic              pass_q, pass_n;
   logic              tmo_hit;

   logic [ADDR_W-1:0] addr;
   logic [31:0]       sum;
   logic [31:0]       pat;
   logic              last;

   assign addr = base_q + idx_q;
   assign sum  = seed_q + 32'(idx_q);
   assign pat  = idx_q[0] ? ~sum : sum;
   assign last = (idx_q == cnt_q - ONE);

`ifdef MASTER_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic        waiting;

   always_comb begin
      waiting = 1'b0;
      unique case (state_q)
         WR, RD:  waiting = avm_m0_waitrequest;
         RD_WAIT: waiting = !avm_m0_readdatavalid;
         default: waiting = 1'b0;
      endcase
   end

   assign tmo_hit = waiting && (tmo_q == 16'(TIMEOUT_CYC - 1));

   // Counts consecutive stalled cycles of the current access only
   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n)
         tmo_q <= '0;
      else if (waiting && !tmo_hit)
         tmo_q <= tmo_q + 16'd1;
      else
         tmo_q <= '0;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYC != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      base_n  = base_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      fea_n   = fea_q;
      seed_n  = seed_q;
      err_n   = err_q;
      to_n    = to_q;
      pass_n  = pass_q;
      unique case (state_q)
         IDLE: begin
            if (ctl_start) begin
               base_n  = ctl_base;
               cnt_n   = ctl_count;
               seed_n  = ctl_seed;
               idx_n   = '0;
               err_n   = '0;
               fea_n   = '0;
               to_n    = 1'b0;
               pass_n  = 1'b0;
               state_n = (ctl_count == '0) ? DONE : WR;
            end
         end
         WR: begin
            if (tmo_hit) begin
               to_n    = 1'b1;
               state_n = DONE;
            end else if (!avm_m0_waitrequest) begin
               if (last) begin
                  idx_n   = '0;
                  state_n = RD;
               end else begin
                  idx_n = idx_q + ONE;
               end
            end
         end
         RD: begin
            if (tmo_hit) begin
               to_n    = 1'b1;
               state_n = DONE;
            end else if (!avm_m0_waitrequest) begin
               state_n = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (tmo_hit) begin
               to_n    = 1'b1;
               state_n = DONE;
            end else if (avm_m0_readdatavalid) begin
               if (avm_m0_readdata != pat) begin
                  if (err_q != '1)
                     err_n = err_q + ONE_E;
                  if (err_q == '0)
                     fea_n = addr;
               end
               if (last) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx_q + ONE;
                  state_n = RD;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Verdict is settled on entry so it is already valid during the done pulse
      if (state_n == DONE && state_q != DONE)
         pass_n = (err_n == '0) && !to_n;
   end

   always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
      if (!rsi_MRST_reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         fea_q   <= '0;
         seed_q  <= '0;
         err_q   <= '0;
         to_q    <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         base_q  <= base_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         fea_q   <= fea_n;
         seed_q  <= seed_n;
         err_q   <= err_n;
         to_q    <= to_n;
         pass_q  <= pass_n;
      end
   end

   assign ctl_busy           = (state_q == WR) || (state_q == RD) ||
                               (state_q == RD_WAIT);
   assign ctl_done           = (state_q == DONE);
   assign ctl_pass           = pass_q;
   assign ctl_err_count      = err_q;
   assign ctl_first_err_addr = fea_q;
   assign ctl_timeout        = to_q;

   assign avm_m0_write      = (state_q == WR);
   assign avm_m0_read       = (state_q == RD);
   assign avm_m0_address    = (avm_m0_write || avm_m0_read) ? addr : '0;
   assign avm_m0_writedata  = avm_m0_write ? pat : '0;
   assign avm_m0_byteenable = (avm_m0_write || avm_m0_read) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_avalon_master_rw32_tester.sv
// Scoreboard bench: RAM slave with wait states/latency/corruption, model of expected
// bus accesses and run verdicts, monitor comparing on every acceptance and done pulse.
module tb_avalon_master_rw32_tester;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] count = '0;
   logic [31:0]   seed = '0;
   logic          busy, done, pass, tmo;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic [31:0]   writedata;
   logic          write, read;
   logic [31:0]   readdata;
   logic          readdatavalid;
   logic          waitrequest;

   always #5 clk = ~clk;

   avalon_master_rw32_tester #(.ADDR_W(AW), .TIMEOUT_CYC(255)) dut (
      .rsi_MRST_reset_n     (rst_n),
      .csi_MCLK_clk         (clk),
      .ctl_start            (start),
      .ctl_base             (base),
      .ctl_count            (count),
      .ctl_seed             (seed),
      .ctl_busy             (busy),
      .ctl_done             (done),
      .ctl_pass             (pass),
      .ctl_err_count        (err_count),
      .ctl_first_err_addr   (first_err_addr),
      .ctl_timeout          (tmo),
      .avm_m0_address       (address),
      .avm_m0_byteenable    (byteenable),
      .avm_m0_writedata     (writedata),
      .avm_m0_write         (write),
      .avm_m0_read          (read),
      .avm_m0_readdata      (readdata),
      .avm_m0_readdatavalid (readdatavalid),
      .avm_m0_waitrequest   (waitrequest)
   );

   // Slave model
   int            cfg_wait = 0;
   int            cfg_lat = 1;
   bit            cfg_drop = 0;
   bit            cfg_cor = 0;
   logic [AW-1:0] cfg_caddr = '0;
   logic [31:0]   mem [64];
   int            stall;
   int            rd_timer;
   logic [31:0]   rd_q;

   assign waitrequest   = (write || read) && (stall < cfg_wait);
   assign readdatavalid = (rd_timer == 1) && !cfg_drop;
   assign readdata      = readdatavalid ? rd_q : 32'h5A5A_A5A5;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall    <= 0;
         rd_timer <= 0;
         rd_q     <= '0;
      end else begin
         if ((write || read) && waitrequest) stall <= stall + 1;
         else stall <= 0;
         if (write && !waitrequest) mem[address] <= writedata;
         if (read && !waitrequest) begin
            rd_timer <= cfg_lat;
            rd_q <= mem[address] ^ {31'b0, cfg_cor && (address == cfg_caddr)};
         end else if (rd_timer > 0) begin
            rd_timer <= rd_timer - 1;
         end
      end
   end

   // Scoreboard
   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } acc_t;
   typedef struct {
      logic          pass;
      logic [AW:0]   err;
      logic [AW-1:0] fea;
      logic          to;
   } res_t;

   acc_t          wq[$];
   logic [AW-1:0] rq[$];
   res_t          dq[$];
   int            errs = 0;
   int            checks = 0;
   int            done_cnt = 0;
   int            wr_acc = 0;
   int            rd_acc = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: word i goes to (base+i) mod 64 with seed+i, inverted on odd i
   task automatic expect_run(input logic [AW-1:0] b, input int n,
                             input logic [31:0] s, input bit verdict);
      res_t r;
      r.err = '0;
      r.fea = '0;
      r.to  = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc_t e;
         e.a = AW'((int'(b) + i) % 64);
         e.d = s + 32'(i);
         if (i % 2 == 1) e.d = ~e.d;
         wq.push_back(e);
         rq.push_back(e.a);
         if (cfg_cor && e.a == cfg_caddr) begin
            if (r.err == 0) r.fea = e.a;
            r.err = r.err + 1;
         end
      end
      r.pass = (r.err == 0);
      if (verdict) dq.push_back(r);
   endtask

   acc_t          m_e;
   logic [AW-1:0] m_a;
   res_t          m_r;
   logic          p_stall = 1'b0;
   logic [39:0]   p_bus = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_stall = 1'b0;
      end else begin
         if (p_stall)
            chk("hold_on_stall", {write, read, address, writedata}, p_bus);
         p_stall = (write || read) && waitrequest;
         p_bus = {write, read, address, writedata};
         if (write && !waitrequest) begin
            wr_acc++;
            if (wq.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               m_e = wq.pop_front();
               chk("wr_addr", address, m_e.a);
               chk("wr_data", writedata, m_e.d);
               chk("wr_be", byteenable, 4'hF);
            end
         end
         if (read && !waitrequest) begin
            rd_acc++;
            if (rq.size() == 0) begin
               chk("unexpected_read", 1, 0);
            end else begin
               m_a = rq.pop_front();
               chk("rd_addr", address, m_a);
            end
         end
         if (done) begin
            done_cnt++;
            if (dq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               m_r = dq.pop_front();
               chk("pass", pass, m_r.pass);
               chk("err_count", err_count, m_r.err);
               chk("first_err_addr", first_err_addr, m_r.fea);
               chk("timeout", tmo, m_r.to);
               chk("busy_at_done", busy, 0);
               chk("writes_left", wq.size(), 0);
               chk("reads_left", rq.size(), 0);
            end
         end
      end
   end

   task automatic pulse(input logic [AW-1:0] b, input int n,
                        input logic [31:0] s);
      @(posedge clk);
      #1;
      base  = b;
      count = AW'(n);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run(input logic [AW-1:0] b, input int n, input logic [31:0] s,
                      input int w, input int lat, input bit cor,
                      input logic [AW-1:0] ca, input bit poke);
      int d0, w0, r0;
      cfg_wait  = w;
      cfg_lat   = lat;
      cfg_cor   = cor;
      cfg_caddr = ca;
      d0 = done_cnt;
      w0 = wr_acc;
      r0 = rd_acc;
      expect_run(b, n, s, 1'b1);
      pulse(b, n, s);
      chk("first_write_latency", write, n > 0);
      chk("busy_after_start", busy, n > 0);
      chk("done_after_start", done, n == 0);
      if (poke) begin
         repeat (5) @(posedge clk);
         pulse(b + 6'd7, n + 3, ~s);
      end
      for (int k = 0; k < 4000 && done_cnt == d0; k++) @(posedge clk);
      chk("run_completed", done_cnt - d0, 1);
      chk("write_accepts", wr_acc - w0, n);
      chk("read_accepts", rd_acc - r0, n);
      repeat (2) @(posedge clk);
   endtask

   logic [60:0] outs;
   assign outs = {busy, done, pass, err_count, first_err_addr, tmo,
                  address, byteenable, writedata, write, read};

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs, 0);
      rst_n = 1'b1;

      run(6'd0, 4, 32'h10, 0, 1, 0, 6'd0, 0);
      run(6'd0, 4, $urandom, 15, 1, 0, 6'd0, 1);
      run(6'd0, 4, $urandom, 0, 1, 1, 6'd2, 0);
      run(6'd62, 4, $urandom, 0, 2, 0, 6'd0, 0);
      run(6'd17, 0, $urandom, 0, 1, 0, 6'd0, 0);
      for (int t = 0; t < 12; t++)
         run(AW'($urandom), $urandom_range(1, 20), $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3),
             1'($urandom_range(0, 1)), AW'($urandom), 0);

      // Slave that never answers a read
      cfg_wait = 0;
      cfg_cor  = 0;
      cfg_drop = 1;
      expect_run(6'd5, 1, 32'hCAFE0000, 1'b0);
`ifdef MASTER_TIMEOUT_EN
      dq.push_back('{pass: 1'b0, err: '0, fea: '0, to: 1'b1});
      d0 = done_cnt;
      pulse(6'd5, 1, 32'hCAFE0000);
      for (int k = 0; k < 400 && done_cnt == d0; k++) @(posedge clk);
      chk("timeout_done", done_cnt - d0, 1);
      expect_run(6'd5, 1, 32'hCAFE0000, 1'b0);
      pulse(6'd5, 1, 32'hCAFE0000);
      repeat (20) @(posedge clk);
`else
      pulse(6'd5, 1, 32'hCAFE0000);
      repeat (300) @(posedge clk);
      #1;
      chk("stuck_busy", busy, 1);
      chk("stuck_read_low", read, 0);
`endif
      d0 = done_cnt;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", outs, 0);
      wq.delete();
      rq.delete();
      dq.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("no_done_on_abort", done_cnt - d0, 0);
      rst_n = 1'b1;
      cfg_drop = 0;
      run(6'd0, 4, $urandom, 0, 2, 0, 6'd0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
